// File: rtl/dcim_pkg.sv
// Shared types and requantization helpers for the digital_circuit result path.
// shift_round and sat_clip are the two pipeline halves; sat_round chains them.
package dcim_pkg;

    localparam int NOUT_W    = 51;
    localparam int OUT_W     = 16;
    localparam int SHAMT_MAX = 50;

    typedef logic signed [NOUT_W:0] wide_t;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] word;
    } req_t;

    localparam wide_t SAT_HI = wide_t'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam wide_t SAT_LO = wide_t'(-(64'sd1 <<< (OUT_W - 1)));

    // The extra top bit keeps the round-up carry of the largest positive value from wrapping.
    function automatic wide_t shift_round(input logic [NOUT_W-1:0] value,
                                          input logic [5:0]        shamt);
        logic [5:0] sh;
        wide_t      ext;
        wide_t      rnd;
        sh  = (shamt > 6'(SHAMT_MAX)) ? 6'(SHAMT_MAX) : shamt;
        ext = {value[NOUT_W-1], value};
        rnd = '0;
        if (sh != 6'd0) begin
            rnd[0] = value[sh - 6'd1];
        end else begin
            rnd[0] = 1'b0;
        end
        return (ext >>> sh) + rnd;
    endfunction

    function automatic req_t sat_clip(input wide_t y, input logic relu);
        wide_t v;
        req_t  r;
        if (relu && y[NOUT_W]) begin
            v = '0;
        end else begin
            v = y;
        end
        if (v > SAT_HI) begin
            r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < SAT_LO) begin
            r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = {1'b0, v[OUT_W-1:0]};
        end
        return r;
    endfunction

    function automatic req_t sat_round(input logic [NOUT_W-1:0] value,
                                       input logic [5:0]        shamt,
                                       input logic              relu);
        return sat_clip(shift_round(value, shamt), relu);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; rd_data holds the last popped
// value while empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] head_s;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;

    assign full_s = (level_r == LW'(DEPTH));

    // Next head: the word being written bypasses memory when it lands at the new read slot.
    always_comb begin
        pop_s     = rd_en & valid_r;
        push_s    = wr_en & (~full_s | pop_s);
        rd_next_s = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1'b1);
            2'b01:   level_next_s = level_r - LW'(1'b1);
            default: level_next_s = level_r;
        endcase
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_s = wr_data;
        end else begin
            head_s = mem_r[rd_next_s];
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            valid_r   <= 1'b0;
            rd_data_r <= '0;
        end else if (clr) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            valid_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_next_s;
            level_r  <= level_next_s;
            valid_r  <= (level_next_s != '0);
            if (level_next_s != '0) begin
                rd_data_r <= head_s;
            end
        end
    end

    assign rd_data = rd_data_r;
    assign valid   = valid_r;
    assign full    = full_s;
    assign level   = level_r;

endmodule

// File: rtl/nout_collector.sv
// Requantizes each completed accumulator result (shift, round, ReLU, saturate)
// and queues it on a valid/ready stream with overflow and saturation reporting.
module nout_collector #(
    parameter int IN_W   = dcim_pkg::NOUT_W,
    parameter int OUT_W  = dcim_pkg::OUT_W,
    parameter int DEPTH  = 4,
    parameter int SCNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     st,
    input  logic [IN_W-1:0]          nout,
    input  logic [5:0]               shamt,
    input  logic                     relu_en,
    input  logic                     clr,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [SCNT_W-1:0]        sat_cnt
);

    import dcim_pkg::*;

    logic              st_q_r;
    logic              p1_valid_r;
    wide_t             p1_y_r;
    logic              p1_relu_r;
    logic              p2_valid_r;
    logic              p2_sat_r;
    logic [OUT_W-1:0]  p2_word_r;
    logic              ovf_r;
    logic [SCNT_W-1:0] sat_cnt_r;
    req_t              req_s;
    logic              fifo_full_s;
    logic              pop_s;
    logic              accept_s;
    logic              drop_s;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    always_comb begin
        req_s    = sat_clip(p1_y_r, p1_relu_r);
        pop_s    = dout_valid & dout_ready;
        accept_s = p2_valid_r & (~fifo_full_s | pop_s);
        drop_s   = p2_valid_r & fifo_full_s & ~pop_s;
    end

    // Capture and requantization pipeline; clr kills every in-flight result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q_r     <= 1'b0;
            p1_valid_r <= 1'b0;
            p1_y_r     <= '0;
            p1_relu_r  <= 1'b0;
            p2_valid_r <= 1'b0;
            p2_sat_r   <= 1'b0;
            p2_word_r  <= '0;
        end else if (clr) begin
            st_q_r     <= 1'b0;
            p1_valid_r <= 1'b0;
            p2_valid_r <= 1'b0;
        end else begin
            st_q_r     <= st;
            p1_valid_r <= st_q_r;
            p2_valid_r <= p1_valid_r;
            if (st_q_r) begin
                p1_y_r    <= shift_round(nout, shamt);
                p1_relu_r <= relu_en;
            end
            if (p1_valid_r) begin
                p2_sat_r  <= req_s.sat;
                p2_word_r <= req_s.word;
            end
        end
    end

    // Sticky overflow and saturating count of saturated words actually queued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_r     <= 1'b0;
            sat_cnt_r <= '0;
        end else if (clr) begin
            ovf_r     <= 1'b0;
            sat_cnt_r <= '0;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
            if (accept_s && p2_sat_r && (sat_cnt_r != {SCNT_W{1'b1}})) begin
                sat_cnt_r <= sat_cnt_r + SCNT_W'(1'b1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .wr_en   (p2_valid_r & ~clr),
        .wr_data (p2_word_r),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .valid   (dout_valid),
        .full    (fifo_full_s),
        .level   (level)
    );

    assign ovf     = ovf_r;
    assign sat_cnt = sat_cnt_r;

endmodule

// File: tb/tb_nout_collector.sv
// Directed bench for nout_collector: latency, rounding, ReLU, saturation,
// overflow, full read/write, back-to-back, clr and asynchronous reset.
module tb_nout_collector;

    logic        clk = 1'b0;
    logic        rstn;
    logic        st;
    logic [50:0] nout;
    logic [5:0]  shamt;
    logic        relu_en;
    logic        clr;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  level;
    logic        ovf;
    logic [7:0]  sat_cnt;

    int checks = 0;
    int errors = 0;

    nout_collector dut (
        .clk        (clk),
        .rstn       (rstn),
        .st         (st),
        .nout       (nout),
        .shamt      (shamt),
        .relu_en    (relu_en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .ovf        (ovf),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // st for one edge, then one quiet cycle so nout is still stable when sampled.
    task automatic pulse(input logic [50:0] n, input logic [5:0] sh, input logic relu);
        nout    = n;
        shamt   = sh;
        relu_en = relu;
        st      = 1'b1;
        tick();
        st = 1'b0;
        tick();
    endtask

    task automatic run_one(input string tag, input logic [50:0] n, input logic [5:0] sh,
                           input logic relu, input logic [15:0] exp);
        dout_ready = 1'b0;
        pulse(n, sh, relu);
        tick();
        tick();
        check_val(tag, {47'd0, dout_valid, dout}, {47'd0, 1'b1, exp});
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    logic [15:0] exp_q [4];

    initial begin
        rstn = 1'b0; st = 1'b0; nout = '0; shamt = 6'd0; relu_en = 1'b0;
        clr = 1'b0; dout_ready = 1'b0;
        #23;
        check_val("rst_dout", {48'd0, dout}, 64'd0);
        check_val("rst_valid", {63'd0, dout_valid}, 64'd0);
        check_val("rst_level", {61'd0, level}, 64'd0);
        check_val("rst_ovf", {63'd0, ovf}, 64'd0);
        check_val("rst_sat", {56'd0, sat_cnt}, 64'd0);
        rstn = 1'b1;
        tick(); tick();

        // basic path with latency 4
        pulse(51'h100, 6'd4, 1'b0);
        tick();
        check_val("lat_e3_valid", {63'd0, dout_valid}, 64'd0);
        tick();
        check_val("lat_e4_valid", {63'd0, dout_valid}, 64'd1);
        check_val("basic_dout", {48'd0, dout}, 64'd16);
        check_val("basic_level1", {61'd0, level}, 64'd1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_val("basic_level0", {61'd0, level}, 64'd0);
        check_val("basic_empty", {63'd0, dout_valid}, 64'd0);
        check_val("basic_hold", {48'd0, dout}, 64'd16);

        // rounding, ReLU, shift clamp, saturation
        run_one("rnd_neg", -51'sd24, 6'd4, 1'b0, 16'hFFFF);
        run_one("relu_neg", -51'sd24, 6'd4, 1'b1, 16'h0000);
        run_one("rnd_up", 51'd3, 6'd1, 1'b0, 16'h0002);
        run_one("sh_clamp_max", 51'h3FFFFFFFFFFFF, 6'd63, 1'b0, 16'h0001);
        run_one("sh_clamp_min", 51'h4000000000000, 6'd63, 1'b0, 16'hFFFF);
        check_val("nosat_cnt", {56'd0, sat_cnt}, 64'd0);
        run_one("sat_pos", 51'sd1 <<< 40, 6'd0, 1'b0, 16'h7FFF);
        check_val("sat_cnt1", {56'd0, sat_cnt}, 64'd1);
        run_one("sat_neg", -(51'sd1 <<< 40), 6'd0, 1'b0, 16'h8000);
        check_val("sat_cnt2", {56'd0, sat_cnt}, 64'd2);

        // overflow: 5 results into a 4-deep FIFO with the consumer stalled
        dout_ready = 1'b0;
        for (int i = 1; i <= 5; i++) pulse(51'(i * 10), 6'd0, 1'b0);
        tick(); tick(); tick();
        check_val("ovf_level", {61'd0, level}, 64'd4);
        check_val("ovf_flag", {63'd0, ovf}, 64'd1);
        check_val("ovf_satcnt", {56'd0, sat_cnt}, 64'd2);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("ovf_order", {48'd0, dout}, 64'((i + 1) * 10));
            tick();
        end
        check_val("ovf_drained", {63'd0, dout_valid}, 64'd0);
        dout_ready = 1'b0;
        check_val("ovf_sticky", {63'd0, ovf}, 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_ovf", {63'd0, ovf}, 64'd0);
        check_val("clr_sat", {56'd0, sat_cnt}, 64'd0);

        // full FIFO with a pop in the same cycle the next write lands
        for (int i = 1; i <= 4; i++) pulse(51'(i), 6'd0, 1'b0);
        tick(); tick();
        check_val("full_level", {61'd0, level}, 64'd4);
        pulse(51'd5, 6'd0, 1'b0);
        tick();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_val("rw_level", {61'd0, level}, 64'd4);
        check_val("rw_ovf", {63'd0, ovf}, 64'd0);
        exp_q = '{16'd2, 16'd3, 16'd4, 16'd5};
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("rw_order", {48'd0, dout}, {48'd0, exp_q[i]});
            tick();
        end
        check_val("rw_drained", {63'd0, dout_valid}, 64'd0);

        // back-to-back st; nout follows one cycle behind st
        shamt = 6'd0; relu_en = 1'b0;
        st = 1'b1;
        tick();
        nout = 51'd1;
        tick();
        nout = 51'd2;
        tick();
        st = 1'b0;
        nout = 51'd3;
        tick();
        for (int i = 1; i <= 3; i++) begin
            check_val("b2b_valid", {63'd0, dout_valid}, 64'd1);
            check_val("b2b_dout", {48'd0, dout}, 64'(i));
            tick();
        end
        check_val("b2b_done", {63'd0, dout_valid}, 64'd0);
        dout_ready = 1'b0;

        // clr with two queued, one in flight, and an st in the clr cycle
        pulse(51'sd1 <<< 40, 6'd0, 1'b0);
        pulse(51'd9, 6'd0, 1'b0);
        tick(); tick();
        check_val("pre_clr_level", {61'd0, level}, 64'd2);
        check_val("pre_clr_sat", {56'd0, sat_cnt}, 64'd1);
        pulse(51'd11, 6'd0, 1'b0);
        clr = 1'b1;
        st  = 1'b1;
        tick();
        clr = 1'b0;
        st  = 1'b0;
        check_val("clr_level", {61'd0, level}, 64'd0);
        check_val("clr_valid", {63'd0, dout_valid}, 64'd0);
        check_val("clr_ovf2", {63'd0, ovf}, 64'd0);
        check_val("clr_sat2", {56'd0, sat_cnt}, 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check_val("clr_killed_valid", {63'd0, dout_valid}, 64'd0);
        check_val("clr_killed_level", {61'd0, level}, 64'd0);

        // asynchronous reset mid-stream
        pulse(51'sd1 <<< 40, 6'd0, 1'b0);
        pulse(51'd7, 6'd0, 1'b0);
        tick(); tick();
        check_val("pre_rst_level", {61'd0, level}, 64'd2);
        check_val("pre_rst_dout", {48'd0, dout}, 64'h7FFF);
        #1;
        rstn = 1'b0;
        #1;
        check_val("arst_dout", {48'd0, dout}, 64'd0);
        check_val("arst_valid", {63'd0, dout_valid}, 64'd0);
        check_val("arst_level", {61'd0, level}, 64'd0);
        check_val("arst_sat", {56'd0, sat_cnt}, 64'd0);
        #3;
        rstn = 1'b1;
        tick();
        pulse(51'h100, 6'd4, 1'b0);
        tick();
        check_val("post_rst_e3", {63'd0, dout_valid}, 64'd0);
        tick();
        check_val("post_rst_e4", {47'd0, dout_valid, dout}, {47'd0, 1'b1, 16'd16});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
